// File: rtl/keen_pkg.sv
// Shared types for the instruction fetch stage: FSM states, fetch-buffer entry, alignment helper.
package keen_pkg;

    localparam int FETCH_XLEN = 32;
    localparam int FETCH_ILEN = 32;
    localparam int IALIGN     = FETCH_ILEN / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ILEN-1:0] inst;
        logic [FETCH_XLEN-1:0] pc;
        logic                  misaligned;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [FETCH_XLEN-1:0] addr);
        return (addr % FETCH_XLEN'(IALIGN)) != '0;
    endfunction

endpackage

// File: rtl/keen_instruction_fetch_if.sv
// Memory request/response and decode channels of the fetch stage; master is the fetch side.
interface keen_instruction_fetch_if
    import keen_pkg::*;
#(
    parameter int XLEN = FETCH_XLEN,
    parameter int ILEN = FETCH_ILEN
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_misaligned;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, inst_pc, inst_misaligned,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, inst_pc, inst_misaligned,
        output inst_ready
    );
endinterface

// File: rtl/keen_fetch_buffer.sv
// Synchronous FIFO of fetch entries; head is a registered array slot, push+pop when full both occur.
// clear wins over push and pop in the same cycle.
module keen_fetch_buffer
    import keen_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  fetch_entry_t               push_entry,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is zeroed only on reset so the head reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !clear) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/keen_instruction_fetch.sv
// Fetch stage: one outstanding imem request, buffered to decode; accept-to-decode 2 cycles at zero wait.
// Stops requesting when the buffer would be full; KEEN_IFETCH_MISALIGN_CHECK_EN enables misaligned-pc faults.
module keen_instruction_fetch
    import keen_pkg::*;
#(
    parameter int XLEN  = FETCH_XLEN,
    parameter int ILEN  = FETCH_ILEN,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [XLEN-1:0]               pc,
    input  logic                          branch,
    output logic                          pc_advance,
    keen_instruction_fetch_if.master      bus
);
`ifdef KEEN_IFETCH_MISALIGN_CHECK_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif
    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t    state, state_next;
    logic            kill, kill_next;
    logic            halted, halted_next;
    logic [XLEN-1:0] req_addr, req_addr_next;
    logic [CW-1:0]   count, count_pop;
    logic            pop, rsp_push, fault_push, accept, pc_bad;
    fetch_entry_t    push_entry, head;

    assign accept    = (state == REQ) && bus.imem_req_ready;
    assign pop       = (count != '0) && bus.inst_ready;
    assign count_pop = count - CW'(pop);
    assign pc_bad    = MISALIGN_EN && is_misaligned(pc);

    always_comb begin
        state_next    = state;
        kill_next     = kill;
        halted_next   = halted;
        req_addr_next = req_addr;
        pc_advance    = 1'b0;
        rsp_push      = 1'b0;
        fault_push    = 1'b0;
        unique case (state)
            // A branch in IDLE holds one cycle so the redirected pc is the one latched.
            IDLE: if (!branch && !halted && int'(count_pop) < DEPTH) begin
                if (pc_bad) begin
                    fault_push  = 1'b1;
                    halted_next = 1'b1;
                end else begin
                    state_next    = REQ;
                    req_addr_next = pc;
                end
            end
            REQ: if (accept) begin
                // A killed request must not advance the counter past the new target.
                pc_advance = !kill && !branch;
                state_next = (kill || branch) ? DRAIN : WAIT;
                kill_next  = 1'b0;
            end else if (branch) begin
                kill_next = 1'b1;
            end
            WAIT: if (bus.imem_rsp_valid) begin
                if (branch) begin
                    state_next = IDLE;
                end else begin
                    rsp_push = 1'b1;
                    if (int'(count_pop) + 1 < DEPTH && !pc_bad) begin
                        state_next    = REQ;
                        req_addr_next = pc;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end else if (branch) begin
                state_next = DRAIN;
            end
            DRAIN: if (bus.imem_rsp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (branch) halted_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            kill     <= 1'b0;
            halted   <= 1'b0;
            req_addr <= '0;
        end else begin
            state    <= state_next;
            kill     <= kill_next;
            halted   <= halted_next;
            req_addr <= req_addr_next;
        end
    end

    // req_addr stays put from acceptance until the next REQ load, so it serves as the response tag.
    assign push_entry.inst       = fault_push ? '0 : bus.imem_rsp_data;
    assign push_entry.pc         = fault_push ? pc : req_addr;
    assign push_entry.misaligned = fault_push;

    keen_fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (rsp_push || fault_push),
        .pop        (pop),
        .clear      (branch),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    assign bus.imem_req_valid  = (state == REQ);
    assign bus.imem_req_addr   = req_addr;
    assign bus.inst_valid      = (count != '0);
    assign bus.inst            = head.inst;
    assign bus.inst_pc         = head.pc;
    assign bus.inst_misaligned = head.misaligned && MISALIGN_EN;

endmodule

// File: tb/tb_keen_instruction_fetch.sv
// Directed scenarios plus randomized traffic against a program-order model of the fetch stage.
module tb_keen_instruction_fetch;
    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            branch;
    logic            pc_advance;
    logic [XLEN-1:0] pc;

    always #5 clk = ~clk;

    keen_instruction_fetch_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

    keen_instruction_fetch #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .branch     (branch),
        .pc_advance (pc_advance),
        .bus        (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int consumed = 0;
    int n, c0;
    int adv_log[$];
    int fire_log[$];

    logic [31:0] model_pc, exp_next, br_target, mem_addr, hold_addr;
    bit          pending;
    int          cnt, mem_delay;
    bit          addr_ok;

    bit          s_adv, s_req_v, s_acc, s_iv, s_fire, s_br, s_rsp, s_mis;
    logic [31:0] s_addr, s_inst, s_ipc;

    function automatic logic [31:0] idata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, then update the counter/memory/program-order models.
    task automatic cycle();
        @(negedge clk);
        s_adv   = pc_advance;
        s_req_v = bus.imem_req_valid;
        s_addr  = bus.imem_req_addr;
        s_acc   = bus.imem_req_valid && bus.imem_req_ready;
        s_iv    = bus.inst_valid;
        s_inst  = bus.inst;
        s_ipc   = bus.inst_pc;
        s_mis   = bus.inst_misaligned;
        s_br    = branch;
        s_rsp   = bus.imem_rsp_valid;
        s_fire  = bus.inst_valid && bus.inst_ready && !branch && !reset;
        if (s_adv) adv_log.push_back(cyc);
        if (s_acc && !reset) chk("one_outstanding", 64'(pending), 64'(0));
        if (s_fire) begin
            fire_log.push_back(cyc);
            chk("inst_pc", 64'(s_ipc), 64'(exp_next));
            chk("inst_data", 64'(s_inst), 64'(idata(exp_next)));
            exp_next = exp_next + 32'd4;
            consumed++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            pending  = 1'b0;
            exp_next = model_pc;
        end else begin
            if (s_br)       model_pc = br_target;
            else if (s_adv) model_pc = model_pc + 32'd4;
            if (s_br) exp_next = br_target;
            if (s_rsp) pending = 1'b0;
            if (s_acc) begin
                pending  = 1'b1;
                cnt      = mem_delay;
                mem_addr = s_addr;
            end else if (pending && cnt > 0) begin
                cnt--;
            end
        end
        pc                 = model_pc;
        branch             = 1'b0;
        bus.imem_rsp_valid = pending && (cnt == 0);
        bus.imem_rsp_data  = pending ? idata(mem_addr) : 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        branch = 1'b0;
        model_pc = 32'h8000_0000;
        pc = model_pc;
        exp_next = model_pc;
        br_target = '0;
        pending = 1'b0;
        cnt = 0;
        mem_delay = 0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;

        // Reset state
        repeat (3) cycle();
        chk("rst_req_valid", 64'(s_req_v), 64'(0));
        chk("rst_pc_advance", 64'(s_adv), 64'(0));
        chk("rst_inst_valid", 64'(s_iv), 64'(0));
        chk("rst_req_addr", 64'(s_addr), 64'(0));
        chk("rst_inst", 64'(s_inst), 64'(0));
        chk("rst_inst_pc", 64'(s_ipc), 64'(0));
        chk("rst_misaligned", 64'(s_mis), 64'(0));

        // Zero-wait memory, decode always ready
        reset = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        exp_next = model_pc;
        adv_log.delete();
        fire_log.delete();
        cyc = 0;
        repeat (10) cycle();
        chk("zw_fire_count", 64'(fire_log.size() >= 3), 64'(1));
        chk("zw_first_accept", 64'(adv_log[0]), 64'(1));
        for (int k = 0; k < 3; k++) begin
            chk("zw_adv_spacing", 64'(adv_log[k] - adv_log[0]), 64'(2 * k));
            chk("zw_inst_latency", 64'(fire_log[k] - adv_log[0]), 64'(2 + 2 * k));
        end

        // Decode stalled: buffer fills, requests stop
        bus.inst_ready = 1'b0;
        branch = 1'b1;
        br_target = 32'h8000_0200;
        adv_log.delete();
        repeat (12) cycle();
        chk("stall_adv_count", 64'(adv_log.size()), 64'(DEPTH));
        chk("stall_req_valid", 64'(s_req_v), 64'(0));
        chk("stall_inst_valid", 64'(s_iv), 64'(1));
        chk("stall_head_pc", 64'(s_ipc), 64'(32'h8000_0200));
        c0 = consumed;
        bus.inst_ready = 1'b1;
        repeat (6) cycle();
        chk("stall_drained", 64'((consumed - c0) >= DEPTH), 64'(1));

        // Memory holds ready low
        bus.imem_req_ready = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (!s_req_v && n < 20);
        chk("hold_req_seen", 64'(s_req_v), 64'(1));
        chk("hold_addr_is_pc", 64'(s_addr), 64'(model_pc));
        hold_addr = s_addr;
        adv_log.delete();
        addr_ok = 1'b1;
        repeat (5) begin
            cycle();
            if (s_addr !== hold_addr || !s_req_v) addr_ok = 1'b0;
        end
        chk("hold_addr_stable", 64'(addr_ok), 64'(1));
        chk("hold_no_adv", 64'(adv_log.size()), 64'(0));
        bus.imem_req_ready = 1'b1;
        cycle();
        chk("hold_adv_on_accept", 64'(s_adv), 64'(1));
        cycle();
        chk("hold_single_pulse", 64'(adv_log.size()), 64'(1));

        // Branch while WAIT, response arrives the cycle after
        mem_delay = 1;
        n = 0;
        do begin cycle(); n++; end while (!s_acc && n < 20);
        chk("bw_accept_seen", 64'(s_acc), 64'(1));
        branch = 1'b1;
        br_target = 32'h8000_0100;
        cycle();
        cycle();
        chk("bw_rsp_arrived", 64'(s_rsp), 64'(1));
        cycle();
        chk("bw_inst_valid", 64'(s_iv), 64'(0));
        n = 0;
        do begin cycle(); n++; end while (!s_acc && n < 20);
        chk("bw_new_addr", 64'(s_addr), 64'(32'h8000_0100));

        // Branch with full buffer and decode ready in the same cycle
        mem_delay = 0;
        bus.inst_ready = 1'b0;
        repeat (10) cycle();
        bus.inst_ready = 1'b1;
        branch = 1'b1;
        br_target = 32'h8000_0300;
        cycle();
        chk("bf_full_before", 64'(s_iv), 64'(1));
        cycle();
        chk("bf_empty_next", 64'(s_iv), 64'(0));
        fire_log.delete();
        repeat (8) cycle();
        chk("bf_refetch", 64'(fire_log.size() > 0), 64'(1));

        // Reset mid-transaction
        bus.inst_ready = 1'b0;
        mem_delay = 2;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk("rst_mid_req_valid", 64'(s_req_v), 64'(0));
        chk("rst_mid_inst_valid", 64'(s_iv), 64'(0));

        // Randomized traffic
        c0 = consumed;
        repeat (800) begin
            bus.imem_req_ready = ($urandom_range(0, 9) < 7);
            bus.inst_ready     = ($urandom_range(0, 9) < 6);
            mem_delay          = $urandom_range(0, 2);
            if ($urandom_range(0, 39) == 0) begin
                branch    = 1'b1;
                br_target = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
            end
            cycle();
        end
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (20) cycle();
        chk("rand_progress", 64'((consumed - c0) > 100), 64'(1));

`ifdef KEEN_IFETCH_MISALIGN_CHECK_EN
        bus.inst_ready = 1'b0;
        branch = 1'b1;
        br_target = 32'h8000_0002;
        cycle();
        adv_log.delete();
        repeat (8) cycle();
        chk("mis_no_adv", 64'(adv_log.size()), 64'(0));
        chk("mis_no_req", 64'(s_req_v), 64'(0));
        chk("mis_inst_valid", 64'(s_iv), 64'(1));
        chk("mis_flag", 64'(s_mis), 64'(1));
        chk("mis_inst_pc", 64'(s_ipc), 64'(32'h8000_0002));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keen_instruction_fetch.md
# keen_instruction_fetch

Fetch stage between the program counter and decode. Takes the current `pc`, issues one instruction-memory request at a time over a valid/ready channel, buffers returned instructions with their addresses in a small FIFO, and presents them to decode over a valid/ready channel. On `branch` it flushes buffered and in-flight fetches so that only instructions from the new path reach decode. `pc_advance` tells the program counter when the current address has been consumed.

## Interface
- `XLEN`, 32, address width
- `ILEN`, 32, instruction width; `IALIGN = ILEN/8`
- `DEPTH`, 2, fetch buffer entries, power of two, ≥ 2
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; clock clk
- `pc`  in  XLEN  address to fetch next
- `branch`  in  1  redirect/flush; same cycle as the counter's branch load
- `pc_advance`  out  1  one-cycle pulse; current `pc` accepted by memory
- `imem_req_valid`  out  1  request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  XLEN  request address
- `imem_rsp_valid`  in  1  response valid, one per accepted request, in order
- `imem_rsp_data`  in  ILEN  fetched instruction
- `inst_valid`  out  1  instruction available to decode
- `inst_ready`  in  1  decode consumes
- `inst`  out  ILEN  instruction
- `inst_pc`  out  XLEN  address of `inst`
- `inst_misaligned`  out  1  entry is a misaligned-fetch fault (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT, DRAIN. Reset → IDLE; all outputs 0, FIFO empty.
- IDLE → REQ when FIFO next-cycle occupancy < DEPTH; `imem_req_addr` ← `pc` (registered), `imem_req_valid` ← 1.
- REQ: `imem_req_valid` and `imem_req_addr` held stable until `imem_req_ready`. On accept: `pc_advance` = 1 that cycle, address latched as tag, → WAIT (→ DRAIN if a kill is pending).
- WAIT: on `imem_rsp_valid`, push {data, tag} into FIFO; → REQ if space remains (occupancy after this cycle's push/pop < DEPTH), else IDLE.
- DRAIN: discard the next response, → IDLE.
- `branch`: FIFO cleared same edge; WAIT → DRAIN; in REQ the request still completes (valid not withdrawn) but a kill flag sends it to DRAIN; in IDLE no effect. `branch` has priority over push and pop in the same cycle.
- Responses arriving in IDLE or REQ are ignored.
- One outstanding request maximum; counter holds `pc` because `pc_advance` is low until acceptance.

## Timing
- Zero-wait memory: cycle 0 accept (`pc_advance`=1), cycle 1 `imem_rsp_valid`, cycle 2 `inst_valid` with that instruction; sustained one instruction per 2 cycles.
- `inst`, `inst_pc`, `inst_misaligned` driven from FIFO head registers; no combinational path from `inst_ready` or `imem_rsp_valid` to any output.
- FIFO full with push and pop in same cycle: both occur, occupancy unchanged.
- `reset` mid-transaction: state IDLE next cycle, FIFO empty, kill cleared.

## Configuration
- `KEEN_IFETCH_MISALIGN_CHECK_EN` defined: a `pc` with `pc % IALIGN != 0` is not requested; instead one entry {data 0, `inst_pc`=pc, `inst_misaligned`=1} is pushed and the FSM stays IDLE with no further fetches until `branch`.
- Undefined: no check, `inst_misaligned` tied 0, low bits passed to memory unchanged.

## Structure
- `keen_pkg`: FSM state enum, `IALIGN` derivation, fetch-entry struct {inst, pc, misaligned}.
- One sub-module: `keen_fetch_buffer`, synchronous FIFO with push, pop, clear, count; clear has priority.

## Test plan
- Zero-wait memory, `pc`=0x8000_0000 incrementing by 4, decode always ready → instructions at 0x8000_0000, …_0004, …_0008 appear on cycles 2, 4, 6; `pc_advance` on 0, 2, 4.
- Decode stalled (`inst_ready`=0) → after DEPTH entries buffered, `imem_req_valid` stays 0, `pc_advance` never pulses; release → entries drain in order.
- Memory holds `imem_req_ready`=0 for 5 cycles → `imem_req_addr` constant, `pc_advance` single pulse on acceptance.
- `branch` while WAIT, response arrives next cycle → response dropped, `inst_valid`=0, next request uses new `pc` 0x8000_0100.
- `branch` with `inst_ready`=1 and full FIFO same cycle → FIFO empty next cycle, no instruction double-consumed.
- Macro defined, `pc`=0x8000_0002 → no memory request; `inst_valid`=1, `inst_misaligned`=1, `inst_pc`=0x8000_0002.
